// File: rtl/bram_arb_pkg.sv
// Shared constants and the rotate-priority pick helper for block-RAM port arbiters.
// Pure declarations: no latency, no flow control.
package bram_arb_pkg;
    localparam int BRAM_DATA_W = 32;
    localparam int BRAM_BE_W   = 4;
    localparam int MAX_REQ     = 8;
    localparam int IDX_W       = 3;

    // Slots at or above the caller's requester count must be zero; the scan then
    // wraps at that count even though it walks all MAX_REQ slots.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [IDX_W-1:0]   start);
        logic [MAX_REQ-1:0] pick;
        logic [IDX_W-1:0]   idx;
        pick = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = start + IDX_W'(k);
            if (pick == '0 && valid[idx]) begin
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// Rotate-priority encoder: one-hot first valid index at or after start_i, wrapping at N.
// Combinational, zero latency; no backpressure of its own.
module rr_priority_pick
    import bram_arb_pkg::*;
#(
    parameter int N = 3
)(
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     grant_o
);
    assign grant_o = N'(rr_pick(MAX_REQ'(valid_i), start_i));
endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with bounded locking sharing one BRAM port; accept in 0 cycles, respond 1 cycle later.
// Backpressure: req_ready is the only stall; a losing requester holds its request until accepted.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 13,
    parameter int MAX_LOCK   = 8
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*BRAM_BE_W-1:0]   req_we,
    input  logic [NUM_REQ*BRAM_DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [BRAM_DATA_W-1:0]         rsp_rdata,
    output logic                           mem_clken,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [BRAM_BE_W-1:0]           mem_we,
    output logic [BRAM_DATA_W-1:0]         mem_wdata,
    input  logic [BRAM_DATA_W-1:0]         mem_rdata
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]       LOCK_MAX = 8'(MAX_LOCK);

    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   lock_owner_q, lock_owner_d;
    logic               lock_vld_q, lock_vld_d;
    logic [7:0]         lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q;

    logic [IDX_W-1:0]   rr_start;
    logic [NUM_REQ-1:0] rr_grant;
    logic [NUM_REQ-1:0] lock_oh;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   win_idx;
    logic               lock_hit;
    logic               any_grant;

    assign rr_start = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + IDX_W'(1);

    rr_priority_pick #(.N(NUM_REQ)) u_pick (
        .valid_i (req_valid),
        .start_i (rr_start),
        .grant_o (rr_grant)
    );

    always_comb begin
        lock_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            lock_oh[i] = (lock_owner_q == IDX_W'(i));
        end
    end

    // Once the owner has used up its burst budget the round-robin pick takes over.
    assign lock_hit  = lock_vld_q && (|(lock_oh & req_valid)) && (lock_cnt_q < LOCK_MAX);
    assign grant     = reset ? '0 : (lock_hit ? lock_oh : rr_grant);
    assign any_grant = |grant;
    assign req_ready = grant;
    assign mem_clken = any_grant;

    always_comb begin
        win_idx   = '0;
        mem_addr  = req_addr[ADDR_WIDTH-1:0];
        mem_we    = '0;
        mem_wdata = req_wdata[BRAM_DATA_W-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx   = IDX_W'(i);
                mem_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_we    = req_we[i*BRAM_BE_W +: BRAM_BE_W];
                mem_wdata = req_wdata[i*BRAM_DATA_W +: BRAM_DATA_W];
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        lock_owner_d = lock_owner_q;
        lock_vld_d   = lock_vld_q;
        lock_cnt_d   = lock_cnt_q;
        if (any_grant) begin
            last_grant_d = win_idx;
            if (|(grant & req_lock)) begin
                lock_owner_d = win_idx;
                lock_vld_d   = 1'b1;
                lock_cnt_d   = lock_hit ? lock_cnt_q + 8'd1 : 8'd1;
            end else begin
                lock_vld_d   = 1'b0;
                lock_cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= LAST_IDX;
            lock_owner_q <= '0;
            lock_vld_q   <= 1'b0;
            lock_cnt_q   <= '0;
            rsp_valid_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_owner_q <= lock_owner_d;
            lock_vld_q   <= lock_vld_d;
            lock_cnt_q   <= lock_cnt_d;
            rsp_valid_q  <= grant;
        end
    end

    // Masking with reset drops an acknowledge still in flight when reset arrives.
    assign rsp_valid = reset ? '0 : rsp_valid_q;
    assign rsp_rdata = mem_rdata;
endmodule
